// File: rtl/mem_wb_if.sv
// Handshake and payload bundle between the memory stage and the write-back
// stage. The stage is the slave; the upstream/downstream environment drives
// through the master modport.
interface mem_wb_if #(
  parameter int DATA_W  = 32,
  parameter int N_RES   = 2,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
);
  // Pipeline control
  logic                     flush;

  // Upstream side
  logic                     in_valid;
  logic                     in_ready;
  logic [N_RES*DATA_W-1:0]  in_result;
  logic [RADDR_W-1:0]       in_rw;
  logic                     in_regwr;
  logic                     in_memtoreg;

  // Downstream side
  logic                     out_valid;
  logic                     out_ready;
  logic [N_RES*DATA_W-1:0]  out_result;
  logic [RADDR_W-1:0]       out_rw;
  logic                     out_regwr;
  logic                     out_memtoreg;

  // Statistics
  logic [CNT_W-1:0]         retired_cnt;

  modport master (
    output flush,
    output in_valid, in_result, in_rw, in_regwr, in_memtoreg,
    input  in_ready,
    input  out_valid, out_result, out_rw, out_regwr, out_memtoreg,
    output out_ready,
    input  retired_cnt
  );

  modport slave (
    input  flush,
    input  in_valid, in_result, in_rw, in_regwr, in_memtoreg,
    output in_ready,
    output out_valid, out_result, out_rw, out_regwr, out_memtoreg,
    input  out_ready,
    output retired_cnt
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with a one-entry skid buffer. The head register M
// always drives the outputs; the skid register S catches the entry that was
// accepted while the head was stalled, so in_ready can be a clean register.
// All state changes on the falling edge of clk; rst is asynchronous,
// active-low. A retire counter counts every delivered entry.
module mem_wb_stage #(
  parameter int DATA_W  = 32,
  parameter int N_RES   = 2,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  mem_wb_if.slave      bus
);

  localparam int RES_W = N_RES * DATA_W;

  // One buffered write-back entry
  typedef struct packed {
    logic [RES_W-1:0]   result;
    logic [RADDR_W-1:0] rw;
    logic               regwr;
    logic               memtoreg;
  } entry_t;

  // Occupancy: EMPTY (nothing), ONE (M valid), FULL (M and S valid)
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  entry_t           m_q, m_d;
  entry_t           s_q, s_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             out_valid;
  logic             accept;
  logic             deliver;
  entry_t           in_entry;

  // Handshakes as seen at the falling edge
  assign out_valid = (state_q != EMPTY);
  assign accept    = bus.in_valid & in_ready_q;
  assign deliver   = out_valid & bus.out_ready;

  // Incoming entry; a write to register 0 is squashed at capture time so the
  // register file never sees it
  always_comb begin
    in_entry          = '0;
    in_entry.result   = bus.in_result;
    in_entry.rw       = bus.in_rw;
    in_entry.regwr    = bus.in_regwr & (bus.in_rw != '0);
    in_entry.memtoreg = bus.in_memtoreg;
  end

  // Next-state and datapath selection; flush overrides every transition
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;

    if (bus.flush) begin
      state_d = EMPTY;
      m_d     = '0;
      s_d     = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            m_d     = in_entry;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            m_d = in_entry;
          end else if (accept) begin
            state_d = FULL;
            s_d     = in_entry;
          end else if (deliver) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so no accept can coincide
          if (deliver) begin
            state_d = ONE;
            m_d     = s_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Ready is registered alongside the state it is derived from
  assign in_ready_d = (state_d != FULL);

  // Every delivered entry is retired, including one delivered during flush;
  // the counter wraps naturally
  assign cnt_d = cnt_q + CNT_W'(deliver);

  // State, buffers, ready and counter update on the falling edge
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the two entry buffers are ordinary registers and are cleared
      // here so the outputs read zero during reset without gating.
      state_q    <= EMPTY;
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  // Head fields come from M only; the enables are qualified by out_valid
  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid;
  assign bus.out_result   = m_q.result;
  assign bus.out_rw       = m_q.rw;
  assign bus.out_regwr    = m_q.regwr & out_valid;
  assign bus.out_memtoreg = m_q.memtoreg & out_valid;
  assign bus.retired_cnt  = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed scenarios followed by random traffic,
// all compared each cycle against a queue-based model of the stage.
module tb_mem_wb_stage;

  localparam int DATA_W  = 32;
  localparam int N_RES   = 2;
  localparam int RADDR_W = 5;
  localparam int CNT_W   = 4;
  localparam int RES_W   = N_RES * DATA_W;

  logic clk = 1'b1;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_wb_if #(.DATA_W(DATA_W), .N_RES(N_RES), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) bus ();

  mem_wb_stage #(.DATA_W(DATA_W), .N_RES(N_RES), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [RES_W-1:0]   result;
    logic [RADDR_W-1:0] rw;
    logic               regwr;
    logic               memtoreg;
  } ent_t;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  // Model: an ordered list of at most two held entries and a wrapping count
  ent_t mq[$];
  int   m_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model update at the falling edge, cleared immediately by reset
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      bit del;
      bit acc;
      del = (mq.size() > 0) && bus.out_ready;
      acc = bus.in_valid && (mq.size() < 2);
      if (del) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (bus.flush) begin
        mq.delete();
      end else begin
        ent_t e;
        if (del) void'(mq.pop_front());
        if (acc) begin
          e.result   = bus.in_result;
          e.rw       = bus.in_rw;
          e.regwr    = bus.in_regwr && (bus.in_rw != 0);
          e.memtoreg = bus.in_memtoreg;
          mq.push_back(e);
        end
      end
    end
  end

  // Compare process, half a cycle away from the updating edge
  always @(posedge clk) begin
    if (chk_en) begin
      check("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
      check("in_ready", 64'(bus.in_ready), 64'(mq.size() < 2));
      check("retired_cnt", 64'(bus.retired_cnt), 64'(m_cnt));
      if (mq.size() > 0) begin
        check("out_result", 64'(bus.out_result), 64'(mq[0].result));
        check("out_rw", 64'(bus.out_rw), 64'(mq[0].rw));
        check("out_regwr", 64'(bus.out_regwr), 64'(mq[0].regwr));
        check("out_memtoreg", 64'(bus.out_memtoreg), 64'(mq[0].memtoreg));
      end else begin
        check("out_regwr_idle", 64'(bus.out_regwr), 64'd0);
        check("out_memtoreg_idle", 64'(bus.out_memtoreg), 64'd0);
      end
    end
  end

  // Advance to just after the next rising edge (inputs change, outputs stable)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [RES_W-1:0] r, input logic [RADDR_W-1:0] rw,
                       input bit wr, input bit m2r);
    bus.in_valid    = v;
    bus.in_result   = r;
    bus.in_rw       = rw;
    bus.in_regwr    = wr;
    bus.in_memtoreg = m2r;
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(0, '0, '0, 0, 0);
    #1 rst = 1'b0;
    chk_en = 1;
    step(); step();

    // Reset state
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_cnt", 64'(bus.retired_cnt), 64'd0);
    check("rst_result", 64'(bus.out_result), 64'd0);
    rst = 1'b1;
    step();

    // Pass-through
    bus.out_ready = 1'b1;
    drive(1, {32'h22, 32'h11}, 5'd3, 1, 0);
    step();
    check("pt_valid", 64'(bus.out_valid), 64'd1);
    check("pt_result", 64'(bus.out_result), 64'h00000022_00000011);
    check("pt_rw", 64'(bus.out_rw), 64'd3);
    check("pt_regwr", 64'(bus.out_regwr), 64'd1);
    drive(0, '0, '0, 0, 0);
    step();
    check("pt_cnt", 64'(bus.retired_cnt), 64'd1);
    check("pt_empty", 64'(bus.out_valid), 64'd0);

    // Back-pressure: A then B with the head stalled
    bus.out_ready = 1'b0;
    drive(1, 64'hA, 5'd4, 1, 1);
    step();
    drive(1, 64'hB, 5'd5, 1, 0);
    step();
    drive(0, '0, '0, 0, 0);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_head_a", 64'(bus.out_result), 64'hA);
    check("bp_m2r_a", 64'(bus.out_memtoreg), 64'd1);
    bus.out_ready = 1'b1;
    step();
    check("bp_head_b", 64'(bus.out_result), 64'hB);
    check("bp_cnt_a", 64'(bus.retired_cnt), 64'd2);
    step();
    check("bp_cnt_b", 64'(bus.retired_cnt), 64'd3);
    check("bp_drained", 64'(bus.out_valid), 64'd0);

    // Register-0 write suppression
    bus.out_ready = 1'b0;
    drive(1, 64'h77, 5'd0, 1, 0);
    step();
    check("r0_valid", 64'(bus.out_valid), 64'd1);
    check("r0_regwr", 64'(bus.out_regwr), 64'd0);
    check("r0_rw", 64'(bus.out_rw), 64'd0);

    // Flush while FULL with an entry offered
    drive(1, 64'h88, 5'd7, 1, 0);
    step();
    check("fl_full", 64'(bus.in_ready), 64'd0);
    bus.flush = 1'b1;
    drive(1, 64'h99, 5'd9, 1, 1);
    step();
    bus.flush = 1'b0;
    drive(0, '0, '0, 0, 0);
    check("fl_valid", 64'(bus.out_valid), 64'd0);
    check("fl_in_ready", 64'(bus.in_ready), 64'd1);
    check("fl_cnt", 64'(bus.retired_cnt), 64'd3);
    step();
    check("fl_dropped", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset between edges while FULL
    drive(1, 64'h1, 5'd1, 1, 1);
    step();
    drive(1, 64'h2, 5'd2, 1, 1);
    step();
    drive(0, '0, '0, 0, 0);
    check("ar_full", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("ar_valid", 64'(bus.out_valid), 64'd0);
    check("ar_result", 64'(bus.out_result), 64'd0);
    check("ar_m2r", 64'(bus.out_memtoreg), 64'd0);
    check("ar_cnt", 64'(bus.retired_cnt), 64'd0);
    check("ar_in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b1;
    step();
    check("ar_after", 64'(bus.out_valid), 64'd0);

    // Counter wrap: 17 delivers on a 4-bit counter
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1, 64'(i + 100), 5'(i + 1), 1, 0);
      step();
    end
    drive(0, '0, '0, 0, 0);
    step();
    check("wrap_cnt", 64'(bus.retired_cnt), 64'd1);
    check("wrap_empty", 64'(bus.out_valid), 64'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.flush     = ($urandom_range(0, 19) == 0);
      drive($urandom_range(0, 9) < 7, {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            1'($urandom), 1'($urandom));
      step();
    end
    bus.flush = 1'b0;
    drive(0, '0, '0, 0, 0);
    step(); step();

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
